// File: rtl/multicycle_main_controller_if.sv
// Memory-port handshake bundle for the multicycle main controller.
// The controller drives the request side (master); the memory drives MemReady (slave).
interface multicycle_main_controller_if;
    logic MemReq;    // memory access request
    logic MemWrite;  // write qualifier, meaningful only with MemReq
    logic AdrSrc;    // address select: 0=PC, 1=ALU result
    logic MemReady;  // memory accepts/completes the access this cycle

    modport master (
        output MemReq,
        output MemWrite,
        output AdrSrc,
        input  MemReady
    );

    modport slave (
        input  MemReq,
        input  MemWrite,
        input  AdrSrc,
        output MemReady
    );
endinterface

// File: rtl/multicycle_main_controller.sv
// Multicycle main controller: sequences fetch, decode, execute, memory and
// writeback over one shared memory port with a req/ready handshake and a
// bounded wait (MEM_TIMEOUT) that parks the FSM in a sticky FAULT state.
// Control outputs are decoded from the registered state, qualified by
// MemReady and Zero; strobes are forced low while rst is low.
// Optional feature: define PERF_CNT_EN to build the RetireCount counter;
// without it RetireCount is tied to zero.
module multicycle_main_controller #(
    parameter int MEM_TIMEOUT = 15,  // legal range 1..255
    parameter int PERF_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,        // synchronous, active-low
    multicycle_main_controller_if.master  mem,
    input  logic [6:0]                    Op,
    input  logic                          Zero,
    output logic                          IRWrite,
    output logic                          PCWrite,
    output logic                          RegWrite,
    output logic [1:0]                    ResultSrc,
    output logic [1:0]                    ALUSrcA,
    output logic [1:0]                    ALUSrcB,
    output logic [1:0]                    ALUOp,
    output logic [1:0]                    ImmSrc,
    output logic                          Illegal,
    output logic                          Fault,
    output logic                          InstrDone,
    output logic [PERF_W-1:0]             RetireCount
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_fault;

    // Decoded (ungated) controls; strobes are masked by rst afterwards.
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_instr_done;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;

    // State sequencing, memory wait counter and sticky fault flag.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (mem.MemReady) begin
                        // Completion wins even when the counter sits at the limit.
                        r_wait <= '0;
                        unique case (r_state)
                            S_FETCH:   r_state <= S_DECODE;
                            S_MEMREAD: r_state <= S_MEMWB;
                            default:   r_state <= S_FETCH;
                        endcase
                    end else if (r_wait == WAIT_MAX) begin
                        r_wait  <= '0;
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    unique case (Op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR: r_state <= (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_EXECR,
                S_EXECI,
                S_JAL:    r_state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BEQ,
                S_TRAP:   r_state <= S_FETCH;
                S_FAULT:  r_state <= S_FAULT;  // only reset leaves FAULT
                default:  r_state <= S_FAULT;
            endcase
        end
    end

    // Moore control decode per state, qualified by MemReady where a
    // handshake completes in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default would infer a latch.
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_instr_done = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b0;
                if (mem.MemReady) begin
                    // PC+4 computed on the ALU and loaded as the IR captures.
                    w_ir_write   = 1'b1;
                    w_pc_update  = 1'b1;
                    w_alu_src_a  = 2'b00;
                    w_alu_src_b  = 2'b10;
                    w_alu_op     = 2'b00;
                    w_result_src = 2'b10;
                end
            end
            S_DECODE: begin
                // Branch/jump target OldPC + imm, ready for BEQ/JAL.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
                w_adr_src    = 1'b1;
                w_instr_done = mem.MemReady;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_result_src = 2'b00;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JAL: begin
                // Link value PC+4 (OldPC+4) flows to ALUWB; PC takes the target.
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_alu_op     = 2'b00;
                w_result_src = 2'b00;
                w_pc_update  = 1'b1;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            S_FAULT: begin
                // All controls stay at their idle defaults.
            end
            default: begin
            end
        endcase
    end

    // Immediate format straight from the opcode, independent of state.
    always_comb begin
        unique case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes are masked while rst is low so an abandoned instruction issues nothing.
    assign mem.MemReq   = w_mem_req   & rst;
    assign mem.MemWrite = w_mem_write & rst;
    assign mem.AdrSrc   = w_adr_src;
    assign IRWrite      = w_ir_write  & rst;
    assign PCWrite      = (w_pc_update | (w_branch & Zero)) & rst;
    assign RegWrite     = w_reg_write & rst;
    assign Illegal      = w_illegal   & rst;
    assign InstrDone    = w_instr_done & rst;
    assign ResultSrc    = w_result_src;
    assign ALUSrcA      = w_alu_src_a;
    assign ALUSrcB      = w_alu_src_b;
    assign ALUOp        = w_alu_op;
    assign Fault        = r_fault;

`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] r_retire_count;

    // Retired-instruction counter; wraps naturally at 2^PERF_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retire_count <= '0;
        end else if (w_instr_done) begin
            r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign RetireCount = r_retire_count;
`else
    assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench for multicycle_main_controller: each instruction pushes
// its expected footprint (cycles, strobe counts, mux values) to a scoreboard
// queue; a memory model answers the handshake and the observed footprint is
// popped and compared when the instruction ends.
module tb_multicycle_main_controller;

    localparam int MEM_TIMEOUT = 15;
    localparam int PERF_W      = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        int cycles;
        int ir;
        int pc;
        int reg_w;
        int mem_w;
        int ill;
        int done;
        int fault;
        int rsrc;        // ResultSrc on the RegWrite cycle (3 = none)
        int aluop_prev;  // ALUOp one cycle before RegWrite (3 = none)
        int imm;
    } foot_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [6:0]       Op = 7'd0;
    logic             Zero = 1'b0;
    logic             IRWrite, PCWrite, RegWrite, Illegal, Fault, InstrDone;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [PERF_W-1:0] RetireCount;

    multicycle_main_controller_if bus ();

    multicycle_main_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .PERF_W      (PERF_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus.master),
        .Op          (Op),
        .Zero        (Zero),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ImmSrc      (ImmSrc),
        .Illegal     (Illegal),
        .Fault       (Fault),
        .InstrDone   (InstrDone),
        .RetireCount (RetireCount)
    );

    always #5 clk = ~clk;

    int    n_checks  = 0;
    int    n_fail    = 0;
    int    sb_retired = 0;
    foot_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.MemReq, bus.MemWrite, IRWrite, PCWrite, RegWrite, Illegal, InstrDone};
    endfunction

    // Expected footprint of one instruction from the opcode table and wait counts.
    function automatic foot_t model(input logic [6:0] op, input logic zero, input int fw, input int mw);
        foot_t e;
        e.cycles = 0; e.ir = 0; e.pc = 0; e.reg_w = 0; e.mem_w = 0; e.ill = 0;
        e.done = 0; e.fault = 0; e.rsrc = 3; e.aluop_prev = 3;
        e.imm = (op == OP_SW) ? 1 : (op == OP_BEQ) ? 2 : (op == OP_JAL) ? 3 : 0;
        if (fw > MEM_TIMEOUT) begin
            e.cycles = MEM_TIMEOUT + 2;
            e.fault  = 1;
            return e;
        end
        e.ir = 1;
        e.pc = 1;
        case (op)
            OP_R, OP_I: begin
                e.cycles = 4 + fw; e.reg_w = 1; e.done = 1; e.rsrc = 0; e.aluop_prev = 2;
            end
            OP_LW, OP_SW: begin
                if (mw > MEM_TIMEOUT) begin
                    e.cycles = 3 + fw + MEM_TIMEOUT + 2;
                    e.fault  = 1;
                end else if (op == OP_LW) begin
                    e.cycles = 5 + fw + mw; e.reg_w = 1; e.done = 1; e.rsrc = 1; e.aluop_prev = 0;
                end else begin
                    e.cycles = 4 + fw + mw; e.mem_w = 1; e.done = 1;
                end
            end
            OP_BEQ: begin
                e.cycles = 3 + fw; e.pc = zero ? 2 : 1; e.done = 1;
            end
            OP_JAL: begin
                e.cycles = 4 + fw; e.pc = 2; e.reg_w = 1; e.done = 1; e.rsrc = 0; e.aluop_prev = 0;
            end
            default: begin
                e.cycles = 3 + fw; e.ill = 1;
            end
        endcase
        return e;
    endfunction

    // Entered just after a rising edge; leaves just after the edge that
    // follows the instruction's last cycle.
    task automatic run_instr(input string name, input logic [6:0] op, input logic zero,
                             input int fw, input int mw);
        foot_t e, o;
        int    fl, ml;
        logic [1:0] prev_aluop;
        bit    fin;
        sb_q.push_back(model(op, zero, fw, mw));
        Op = op; Zero = zero; fl = fw; ml = mw; fin = 1'b0; prev_aluop = 2'b11;
        o.cycles = 0; o.ir = 0; o.pc = 0; o.reg_w = 0; o.mem_w = 0; o.ill = 0;
        o.done = 0; o.fault = 0; o.rsrc = 3; o.aluop_prev = 3; o.imm = 0;
        while (!fin && o.cycles < 100) begin
            @(negedge clk);
            if (bus.MemReq && !bus.AdrSrc) begin
                if (fl > 0) begin bus.MemReady = 1'b0; fl--; end
                else bus.MemReady = 1'b1;
            end else if (bus.MemReq) begin
                if (ml > 0) begin bus.MemReady = 1'b0; ml--; end
                else bus.MemReady = 1'b1;
            end else begin
                bus.MemReady = 1'b0;
            end
            #1;
            if (o.cycles == 0) o.imm = int'(ImmSrc);
            o.cycles++;
            if (IRWrite) o.ir++;
            if (PCWrite) o.pc++;
            if (RegWrite) begin
                o.reg_w++;
                o.rsrc       = int'(ResultSrc);
                o.aluop_prev = int'(prev_aluop);
            end
            if (bus.MemReq && bus.MemWrite && bus.MemReady) o.mem_w++;
            if (Illegal) o.ill++;
            if (InstrDone) o.done++;
            if (Fault) begin o.fault = 1; fin = 1'b1; end
            if (InstrDone || Illegal) fin = 1'b1;
            prev_aluop = ALUOp;
        end
        check({name, " finished"}, 64'(fin), 64'd1);
        e = sb_q.pop_front();
        check({name, " cycles"},     64'(o.cycles),     64'(e.cycles));
        check({name, " IRWrite"},    64'(o.ir),         64'(e.ir));
        check({name, " PCWrite"},    64'(o.pc),         64'(e.pc));
        check({name, " RegWrite"},   64'(o.reg_w),      64'(e.reg_w));
        check({name, " MemWrite"},   64'(o.mem_w),      64'(e.mem_w));
        check({name, " Illegal"},    64'(o.ill),        64'(e.ill));
        check({name, " InstrDone"},  64'(o.done),       64'(e.done));
        check({name, " Fault"},      64'(o.fault),      64'(e.fault));
        check({name, " ResultSrc"},  64'(o.rsrc),       64'(e.rsrc));
        check({name, " ALUOp prev"}, 64'(o.aluop_prev), 64'(e.aluop_prev));
        check({name, " ImmSrc"},     64'(o.imm),        64'(e.imm));
        sb_retired += e.done;
        @(posedge clk);
        #1;
`ifdef PERF_CNT_EN
        check({name, " RetireCount"}, 64'(RetireCount), 64'(sb_retired % (1 << PERF_W)));
`else
        check({name, " RetireCount"}, 64'(RetireCount), 64'd0);
`endif
    endtask

    // Holds rst low for n edges; ends just after an edge with rst released.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        bus.MemReady = 1'b1;
        #1;
        check("strobes in reset", 64'(strobes()), 64'd0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("fault after reset",  64'(Fault),                 64'd0);
        check("retire after reset", 64'(RetireCount),           64'd0);
        check("fetch after reset",  64'({bus.MemReq, bus.AdrSrc}), 64'd2);
        sb_retired = 0;
    endtask

    initial begin
        bus.MemReady = 1'b1;
        do_reset(2);

        run_instr("r0",   OP_R,   1'b0, 0, 0);
        run_instr("r1",   OP_R,   1'b0, 0, 0);
        run_instr("i0",   OP_I,   1'b0, 1, 0);
        run_instr("lw3",  OP_LW,  1'b0, 0, 3);
        run_instr("lwf2", OP_LW,  1'b0, 2, 0);
        run_instr("sw0",  OP_SW,  1'b0, 0, 0);
        run_instr("sw2",  OP_SW,  1'b0, 0, 2);
        run_instr("beqz", OP_BEQ, 1'b1, 0, 0);
        run_instr("beqn", OP_BEQ, 1'b0, 0, 0);
        run_instr("jal",  OP_JAL, 1'b0, 0, 0);
        run_instr("bad",  OP_BAD, 1'b0, 0, 0);
        run_instr("rpost",OP_R,   1'b0, 0, 0);

        // Ready arriving exactly when the counter hits the limit completes.
        run_instr("rf15", OP_R,   1'b0, MEM_TIMEOUT, 0);
        run_instr("lw15", OP_LW,  1'b0, 0, MEM_TIMEOUT);

        // Store that never gets ready: sticky fault, no recovery without reset.
        run_instr("swto", OP_SW,  1'b0, 0, 1000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.MemReady = 1'b1;
            #1;
            check("fault sticky",  64'(Fault),     64'd1);
            check("fault strobes", 64'(strobes()), 64'd0);
        end
        @(posedge clk);
        do_reset(1);
        run_instr("rrec", OP_R, 1'b0, 0, 0);

        // Retire counter across a wrap.
        do_reset(1);
        for (int k = 0; k < 17; k++) run_instr($sformatf("rw%0d", k), OP_R, 1'b0, 0, 0);

        // Reset in the middle of an R-type, while in EXECR.
        Op = OP_R;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.MemReady = 1'b1;
            #1;
        end
        check("execr ALUOp", 64'(ALUOp), 64'd2);
        rst = 1'b0;
        #1;
        check("mid reset strobes", 64'(strobes()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid reset retire", 64'(RetireCount),              64'd0);
        check("mid reset fetch",  64'({bus.MemReq, bus.AdrSrc}), 64'd2);
        sb_retired = 0;
        run_instr("rmid", OP_R, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
